lfsr_parity_gen: RTL

Parametrised successor to the 7-bit LFSR/parity generator: a Fibonacci LFSR of configurable width and tap polynomial with a loadable seed, a one-deep valid/ready output stage carrying {parity, state}, zero-lockup protection and sequence-period measurement. It sits between the top-level `tt_um_*` wrapper and any consumer of pseudo-random words: a UART scrambler, a BIST pattern source or the output pins directly.

---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_next.sv | 16 +
 rtl/lfsr_parity_gen.sv | 91 +++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared helpers for the LFSR family: maximal-length tap masks and parity.
package lfsr_pkg;

   localparam int MAX_WIDTH = 16;

   // Fibonacci masks, bit i = state bit i feeds the XOR; all maximal-length.
   function automatic logic [MAX_WIDTH-1:0] lfsr_default_taps(input int width);
      logic [MAX_WIDTH-1:0] taps;
      case (width)
         3:       taps = 16'h0006;
         4:       taps = 16'h000C;
         5:       taps = 16'h0014;
         6:       taps = 16'h0030;
         7:       taps = 16'h0060;
         8:       taps = 16'h00B8;
         9:       taps = 16'h0110;
         10:      taps = 16'h0240;
         11:      taps = 16'h0500;
         12:      taps = 16'h0E08;
         13:      taps = 16'h1C80;
         14:      taps = 16'h3802;
         15:      taps = 16'h6000;
         16:      taps = 16'hD008;
         default: taps = 16'h0000;
      endcase
      return taps;
   endfunction

   function automatic logic parity(input logic [MAX_WIDTH-1:0] vec);
      return ^vec;
   endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational Fibonacci step and state parity for a given width and tap mask.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 7,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH))
) (
   input  logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next_state,
   output logic             par
);

   assign next_state = {state[WIDTH-2:0], ^(state & TAPS)};
   assign par        = parity(MAX_WIDTH'(state));

endmodule

// File: rtl/lfsr_parity_gen.sv
// LFSR word source with loadable seed, one-deep output stage, zero-seed
// substitution and measurement of the sequence period.
module lfsr_parity_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 7,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_data,
   output logic             wrap,
   output logic             lockup,
   output logic [WIDTH-1:0] period
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] start;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] s_next;
   logic             s_par;
   logic [WIDTH-1:0] seed_val;
   logic             slot_free;
   logic             load_acc;
   logic             advance;

   lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_next (
      .state      (s),
      .next_state (s_next),
      .par        (s_par)
   );

   // Handshake: a transfer happens on any rising edge where valid && ready.
   // The output slot is free when empty or being drained this cycle; both a
   // load and an advance need it, and a load wins.
   assign slot_free  = !out_valid || out_ready;
   assign load_ready = slot_free;
   assign load_acc   = load_valid && slot_free;
   assign advance    = ena && slot_free && !load_valid;
   assign seed_val   = (load_data == '0) ? SEED : load_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s         <= SEED;
         start     <= SEED;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         wrap      <= 1'b0;
         lockup    <= 1'b0;
         period    <= '0;
      end else begin
         wrap   <= 1'b0;
         lockup <= 1'b0;
         if (load_acc) begin
            s         <= seed_val;
            start     <= seed_val;
            cnt       <= '0;
            out_valid <= 1'b0;
            lockup    <= (load_data == '0);
         end else if (advance) begin
            out_data  <= {s_par, s};
            s         <= s_next;
            out_valid <= 1'b1;
            // Returning to the start value closes one full cycle of the sequence.
            if (s_next == start) begin
               wrap   <= 1'b1;
               period <= cnt + CNT_ONE;
               cnt    <= '0;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
